// File: rtl/regfile_mp.sv
// regfile_mp: multi-port GPR file with NUM_RD combinational read ports,
// two posedge write ports (w0 = ALU, w1 = load; w1 wins on address
// collision), optional hardwired zero entry, and a sequenced bulk-clear
// engine with a busy/ready handshake.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a read that hits
// an accepted same-cycle write returns that write's data combinationally.
// When undefined, reads return the pre-write contents during the write cycle.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     w0_en_i,
  input  logic [ADDR_W-1:0]        w0_addr_i,
  input  logic [DATA_W-1:0]        w0_data_i,
  input  logic                     w1_en_i,
  input  logic [ADDR_W-1:0]        w1_addr_i,
  input  logic [DATA_W-1:0]        w1_data_i,
  input  logic                     clr_req_i,
  output logic                     clr_busy_o,
  output logic                     wr_ready_o
);

  localparam int DEPTH = 1 << ADDR_W;
  // Entry 0 needs no sweeping when it is hardwired to zero.
  localparam logic [ADDR_W-1:0] FIRST_PTR = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } clrState_e;

  clrState_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic w0Accept;
  logic w1Accept;

  // A write is taken only while the clear engine is idle and, with a zero
  // register, never when it targets entry 0.
  assign w0Accept = w0_en_i && wr_ready_o &&
                    !((ZERO_REG != 0) && (w0_addr_i == '0));
  assign w1Accept = w1_en_i && wr_ready_o &&
                    !((ZERO_REG != 0) && (w1_addr_i == '0));

  // Clear-engine state register: reset forces IDLE and aborts any sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic: IDLE starts a sweep on request, CLEAR walks the
  // pointer up to the last entry and stops there without wrapping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          ptr_d   = FIRST_PTR;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs come straight off the state register.
  always_comb begin
    clr_busy_o = (state_q == CLEAR);
    wr_ready_o = (state_q != CLEAR);
  end

  // Storage: reset zeroes everything at once; otherwise apply w0 then w1 so
  // the load port wins a collision, and let the sweep zero one entry a cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (w0Accept) begin
        mem_q[w0_addr_i] <= w0_data_i;
      end
      if (w1Accept) begin
        mem_q[w1_addr_i] <= w1_data_i;
      end
      if (state_q == CLEAR) begin
        mem_q[ptr_q] <= '0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              hit0;
    logic              hit1;

    assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    assign hit1 = w1Accept && (w1_addr_i == addr);
    assign hit0 = w0Accept && (w0_addr_i == addr);
`else
    assign hit1 = 1'b0;
    assign hit0 = 1'b0;
`endif

    // Read mux: bypassed write data (w1 first) over array content, with the
    // zero register overriding everything.
    always_comb begin
      data = mem_q[addr];
      if (hit1) begin
        data = w1_data_i;
      end else if (hit0) begin
        data = w0_data_i;
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
      end
    end

    assign rd_data_o[k*DATA_W +: DATA_W] = data;
  end

endmodule
